// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared types and constants for the FP32 significand divider
package fp32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DIV0 = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int          FP32_MANT_W = 24;
    localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/register_32bit.sv
// rtl/register_32bit.sv - 32-bit load-enable register with async active-low clear
module register_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 32'h0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fp32_mant_div_seq.sv
// rtl/fp32_mant_div_seq.sv - restoring FP32 significand divider, one quotient bit per clock
module fp32_mant_div_seq
    import fp32_pkg::*;
#(
    parameter int MANT_W = FP32_MANT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MANT_W-1:0] dividend_m,
    input  logic [MANT_W-1:0] divisor_m,
    output logic              busy,
    output logic              valid,
    output logic              div_by_zero,
    output logic [31:0]       result
);

    localparam int Q_W   = MANT_W + 3;
    localparam int CNT_W = $clog2(Q_W);

    div_state_e        state;
    logic [CNT_W-1:0]  count;
    logic [MANT_W:0]   rem;
    logic [MANT_W-1:0] div;
    logic [Q_W-1:0]    q;

    logic              rem_ge;
    logic [MANT_W:0]   rem_sub;
    logic [MANT_W:0]   rem_next;
    logic [Q_W-1:0]    q_next;
    logic              last_iter;
    logic              load;
    logic [31:0]       word;

    // rem < 2*div always holds, so the shifted difference never loses its top bit
    always_comb begin
        rem_ge    = rem >= {1'b0, div};
        rem_sub   = rem - {1'b0, div};
        rem_next  = rem_ge ? {rem_sub[MANT_W-1:0], 1'b0} : {rem[MANT_W-1:0], 1'b0};
        q_next    = {q[Q_W-2:0], rem_ge};
        last_iter = (state == BUSY) && (count == CNT_W'(Q_W - 1));
        load      = last_iter || (state == DIV0);
        word      = 32'h0;
        if (state == DIV0) begin
            word = DIV0_RESULT;
        end else begin
            word[Q_W:0] = {q_next, |rem_next};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            div         <= '0;
            q           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        div         <= divisor_m;
                        rem         <= {1'b0, dividend_m};
                        q           <= '0;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                        state       <= (divisor_m == '0) ? DIV0 : BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    rem   <= rem_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                DIV0: begin
                    div_by_zero <= 1'b1;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == BUSY) || (state == DIV0);
    assign valid = (state == DONE);

    register_32bit u_result_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load),
        .d     (word),
        .q     (result)
    );

endmodule

// File: tb/tb_fp32_mant_div_seq.sv
// tb/tb_fp32_mant_div_seq.sv - directed self-checking bench for fp32_mant_div_seq
module tb_fp32_mant_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] dividend_m;
    logic [23:0] divisor_m;
    logic        busy;
    logic        valid;
    logic        div_by_zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_mant_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend_m  (dividend_m),
        .divisor_m   (divisor_m),
        .busy        (busy),
        .valid       (valid),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    // Returns the number of clock edges after the accepting edge until valid is seen; 0 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [23:0] b);
        @(negedge clk);
        dividend_m = a;
        divisor_m  = b;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic check_div(input string name, input logic [23:0] a, input logic [23:0] b,
                             input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
        int lat;
        pulse_start(a, b);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        wait_valid(lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, result, exp_res);
        end
        checks++;
        if (div_by_zero !== exp_dbz) begin
            errors++;
            $display("FAIL %s div_by_zero: got %b want %b", name, div_by_zero, exp_dbz);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_one_cycle: got %b want 0", name, valid);
        end
        checks++;
        if (result !== exp_res || div_by_zero !== exp_dbz) begin
            errors++;
            $display("FAIL %s hold_after_done: got %h/%b want %h/%b", name, result, div_by_zero,
                     exp_res, exp_dbz);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        dividend_m = 24'h0;
        divisor_m  = 24'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", valid); end
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++; $display("FAIL reset div_by_zero: got %b want 0", div_by_zero);
        end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 0", result); end
        rst_n = 1'b1;
    endtask

    task automatic test_divide();
        check_div("one_by_one",   24'h800000, 24'h800000, 32'h0800_0000, 1'b0, 27);
        check_div("1p5_by_one",   24'hC00000, 24'h800000, 32'h0C00_0000, 1'b0, 27);
        check_div("one_by_1p5",   24'h800000, 24'hC00000, 32'h0555_5555, 1'b0, 27);
        check_div("max_by_one",   24'hFFFFFF, 24'h800000, 32'h0FFF_FFF0, 1'b0, 27);
        check_div("1p5_by_1p5",   24'hC00000, 24'hC00000, 32'h0800_0000, 1'b0, 27);
    endtask

    task automatic test_div_by_zero();
        check_div("div_zero", 24'h800000, 24'h000000, 32'hFFFF_FFFF, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = 0;
        pulse_start(24'hC00000, 24'h800000);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (valid) begin
                lat = i;
                break;
            end
            if (i == 5) begin
                dividend_m = 24'h800000; divisor_m = 24'hC00000; start = 1'b1;
            end else if (i == 20) begin
                dividend_m = 24'h800000; divisor_m = 24'h000000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (lat !== 27) begin errors++; $display("FAIL ignored_start latency: got %0d want 27", lat); end
        checks++;
        if (result !== 32'h0C00_0000) begin
            errors++; $display("FAIL ignored_start result: got %h want 0c000000", result);
        end
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++; $display("FAIL ignored_start div_by_zero: got %b want 0", div_by_zero);
        end
        // Start raised during the DONE cycle begins a new run immediately.
        dividend_m = 24'h800000;
        divisor_m  = 24'hC00000;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b restart: got valid=%b busy=%b want valid=0 busy=1", valid, busy);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 27) begin errors++; $display("FAIL b2b latency: got %0d want 27", lat); end
        checks++;
        if (result !== 32'h0555_5555) begin
            errors++; $display("FAIL b2b result: got %h want 05555555", result);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        pulse_start(24'h800000, 24'h800000);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset flags: got busy=%b valid=%b want 0/0", busy, valid);
        end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL mid_reset result: got %h want 0", result); end
        repeat (40) begin
            @(negedge clk);
            if (valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_reset no_valid: got %0d pulses want 0", seen); end
        rst_n = 1'b1;
        check_div("after_reset", 24'h800000, 24'hC00000, 32'h0555_5555, 1'b0, 27);
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
